// File: rtl/cg_pkg.sv
// Shared types and default sizing for the multi-channel clock-gate controller.
package cg_pkg;
  typedef enum logic [1:0] {
    CG_GATED,
    CG_WAKE,
    CG_RUN,
    CG_COUNT
  } cg_state_e;

  localparam int CG_WAKE_CYC = 2;
  localparam int CG_IDLE_W   = 8;
endpackage

// File: rtl/cg_icg.sv
// Latch-based integrated clock gate: enable is captured only while clk is low,
// so gclk pulses are always full-width copies of clk high phases.
module cg_icg (
  input  logic clk,
  input  logic en_in,
  output logic gclk
);
  logic r_enLatch;

  always_latch begin
    if (!clk) r_enLatch <= en_in;
  end

  assign gclk = clk & r_enLatch;
endmodule

// File: rtl/cg_ctrl_multi.sv
// Multi-channel clock-gate controller: each channel runs an idle-timeout FSM
// that drives its own glitch-free gate cell.
module cg_ctrl_multi
  import cg_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int IDLE_W   = CG_IDLE_W,
  parameter int WAKE_CYC = CG_WAKE_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   en,
  input  logic [IDLE_W-1:0] idle_thresh,
  input  logic              test_en,
  output logic [N_CH-1:0]   gclk,
  output logic [N_CH-1:0]   ack,
  output logic [N_CH-1:0]   gated
);
  localparam int WW = (WAKE_CYC > 1) ? $clog2(WAKE_CYC) : 1;

  // A threshold of zero behaves exactly like one: gate on the first low sample.
  logic [IDLE_W-1:0] w_thr;
  assign w_thr = (idle_thresh == '0) ? IDLE_W'(1) : idle_thresh;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    cg_state_e         r_state, w_next;
    logic [IDLE_W-1:0] r_cnt, w_cntNext;
    logic [WW-1:0]     r_wake, w_wakeNext;
    logic              r_gateEn, r_ack, r_gated;
    logic [IDLE_W:0]   w_cntInc;

    assign w_cntInc = {1'b0, r_cnt} + (IDLE_W + 1)'(1);

    always_comb begin
      w_next     = r_state;
      w_cntNext  = r_cnt;
      w_wakeNext = r_wake;
      case (r_state)
        CG_GATED: begin
          if (en[i]) begin
            w_next     = CG_WAKE;
            w_wakeNext = WW'(WAKE_CYC - 1);
          end
        end
        CG_WAKE: begin
          if (r_wake == '0) w_next = CG_RUN;
          else              w_wakeNext = r_wake - WW'(1);
        end
        CG_RUN: begin
          if (!en[i]) begin
            if (w_thr <= IDLE_W'(1)) begin
              w_next = CG_GATED;
            end else begin
              w_next    = CG_COUNT;
              w_cntNext = IDLE_W'(1);
            end
          end
        end
        CG_COUNT: begin
          if (en[i]) begin
            w_next    = CG_RUN;
            w_cntNext = '0;
          end else if (w_cntInc >= {1'b0, w_thr}) begin
            // Compared live, so a lowered threshold gates immediately.
            w_next    = CG_GATED;
            w_cntNext = '0;
          end else begin
            w_cntNext = w_cntInc[IDLE_W-1:0];
          end
        end
        default: w_next = CG_GATED;
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_state  <= CG_GATED;
        r_cnt    <= '0;
        r_wake   <= '0;
        r_gateEn <= 1'b0;
        r_ack    <= 1'b0;
        r_gated  <= 1'b1;
      end else begin
        r_state  <= w_next;
        r_cnt    <= w_cntNext;
        r_wake   <= w_wakeNext;
        r_gateEn <= (w_next != CG_GATED);
        r_ack    <= (w_next == CG_RUN) || (w_next == CG_COUNT);
        r_gated  <= (w_next == CG_GATED);
      end
    end

    // test_en bypasses the FSM and reset entirely, acting only on the gate cell.
    cg_icg u_icg (
      .clk   (clk),
      .en_in (r_gateEn | test_en),
      .gclk  (gclk[i])
    );

    assign ack[i]   = r_ack;
    assign gated[i] = r_gated;
  end
endmodule

// File: doc/cg_ctrl_multi.md
Name: cg_ctrl_multi

Overview:
- Multi-channel clock-gate controller. Successor to the single-channel enable-driven gate.
- Each channel owns a glitch-free gated clock and an idle-timeout FSM:
  - the gate closes only after the channel's enable has been low for a programmable number of cycles;
  - on wake, the gate reopens and the channel is acknowledged after a fixed settling delay.
- Sits between block-level busy/request signals and the clock inputs of gated sub-blocks.
- Provides a scan/test override.

Parameters:
- N_CH, 4, number of independent gated channels.
- IDLE_W, 8, width of the idle threshold and idle counter.
- WAKE_CYC, 2, cycles spent in WAKE before ack asserts; minimum 1.

Ports:
- clk  in  1  free-running source clock.
- rst  in  1  synchronous active-high reset.
- en  in  N_CH  per-channel clock request/busy, sampled on rising clk.
- idle_thresh  in  IDLE_W  consecutive low en samples before gating, shared by all channels; value 0 is treated as 1.
- test_en  in  1  scan override; forces every gclk to follow clk.
- gclk  out  N_CH  gated clocks.
- ack  out  N_CH  channel clock stable and running.
- gated  out  N_CH  channel gate closed (status).

Behaviour:
- One clock domain, one synchronous active-high reset. All state updates on rising clk.
- Per-channel FSM states: GATED, WAKE, RUN, COUNT. Registered outputs:
  - gate_en = state in {WAKE, RUN, COUNT};
  - ack = state in {RUN, COUNT};
  - gated = (state == GATED).
- Reset: every channel goes to GATED. idle counter = 0, wake counter = 0, ack = 0, gated = 1, gate_en = 0.
- GATED:
  - en = 1 -> WAKE, wake counter loaded.
  - en = 0 -> stay.
- WAKE:
  - Lasts exactly WAKE_CYC cycles, then RUN. en is ignored.
  - If en is low on entering RUN, the channel moves to COUNT on the next edge.
- RUN:
  - en = 0 and idle_thresh <= 1 -> GATED.
  - en = 0 otherwise -> COUNT, cnt = 1.
  - en = 1 -> stay.
- COUNT:
  - en = 1 -> RUN, cnt cleared.
  - en = 0 and cnt+1 >= idle_thresh -> GATED, cnt cleared.
  - Otherwise cnt increments.
- Idle counter rules:
  - idle_thresh is compared live each cycle, so a lowered threshold takes effect immediately.
  - cnt never exceeds idle_thresh, so no wrap occurs.
  - Width is exactly IDLE_W.
- Latency:
  - en high sampled at edge E0 (channel in GATED) -> gate_en high after E0 -> first gclk high phase in the cycle after E0.
  - ack high after E0+WAKE_CYC.
  - Gating occurs at the edge that takes the idle_thresh-th consecutive low sample.
- Gate cell:
  - Latch transparent while clk is low, capturing (gate_en | test_en).
  - gclk = clk AND latched value.
  - No truncated or extra high pulses when gate_en or test_en change in either clk phase.
- test_en:
  - Affects only the gate cell.
  - FSM, ack and gated are unaffected.
  - Overrides rst for gclk.
- Reset mid-operation (any state, any cycle): the channel enters GATED on that edge; in-flight WAKE or COUNT is abandoned.
- Channels are fully independent; simultaneous events on different channels do not interact.

Decomposition:
- Package cg_pkg:
  - cg_state_e enum {CG_GATED, CG_WAKE, CG_RUN, CG_COUNT};
  - default constants for WAKE_CYC and IDLE_W.
- Sub-module cg_icg: one latch-based clock-gating cell (clk, en_in, gclk).
- cg_ctrl_multi generates N_CH copies of the FSM plus cg_icg.
- Target size: 150-250 lines RTL total.

Test Plan:
- Reset: N_CH=4, rst high for 3 cycles with en=4'hF -> gated=4'hF, ack=0, gclk flat low; after release, channels wake per the GATED rule.
- Wake: en[0] rises before edge E0, WAKE_CYC=2 -> gate_en[0] high after E0; gclk[0] pulses from the next high phase; ack[0] rises after E2; other channels stay gated.
- Idle timeout: idle_thresh=3, channel 0 in RUN, en[0] low sampled at E0, E1, E2 -> COUNT after E0, gated[0]=1 and ack[0]=0 after E2, no gclk[0] pulses afterwards.
- Bounce: idle_thresh=3, en[1] low for 2 samples then high -> channel returns to RUN; ack[1] stays 1; gclk[1] uninterrupted; a second 3-cycle low period then gates.
- Test override: all channels gated, test_en=1 -> all gclk follow clk and gated stays 4'hF. Deassert test_en mid high phase -> the current pulse completes full width with no glitch.
- Corners:
  - idle_thresh=0 -> gate closes at the first low sample.
  - rst pulse during WAKE -> GATED, ack never asserts.
  - en[2] and en[3] toggling on the same edge -> independent correct responses.
